vreg_wb_arbiter: RTL and testbench
==================================

// Module: vreg_wb_arbiter
// PURPOSE
//  Controller for the single write port of the 8-entry x 192-bit vector register file.
//  - Arbitrates round-robin between two writeback requesters: port 0 = vector ALU, port 1 = vector load unit.
//  - Drives the file's wr_enable/RD/WD through one output register stage.
//  - Keeps a busy scoreboard of in-flight destinations and flags RAW/WAW hazards to issue.
// PARAMETERS
//  DATA_W   192  vector register width (bits)
//  IDX_W    4    register index width; indices 8..15 are out of range
//  NUM_REGS 8    implemented vector registers
//  CNT_W    32   perf counter width (VREG_WB_PERF_EN only)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  req0_valid  in   1       ALU writeback request
//  req0_rd     in   IDX_W   ALU destination
//  req0_data   in   DATA_W  ALU result
//  req0_ready  out  1       ALU request accepted this cycle (combinational)
//  req1_valid  in   1       load writeback request
//  req1_rd     in   IDX_W   load destination
//  req1_data   in   DATA_W  load data
//  req1_ready  out  1       load request accepted this cycle (combinational)
//  wr_enable   out  1       to register file write enable (registered)
//  RD          out  IDX_W   to register file write index (registered)
//  WD          out  DATA_W  to register file write data (registered)
//  iss_valid   in   1       issue stage commits an instruction writing iss_rd
//  iss_rd      in   IDX_W   destination of issued instruction
//  chk_rs1/2/3 in   IDX_W   sources of instruction being checked
//  chk_rd      in   IDX_W   destination of instruction being checked
//  chk_use     in   4       {rd,rs3,rs2,rs1} operand-valid mask
//  stall       out  1       hazard on checked instruction (combinational)
//  conflict_cnt out CNT_W   cycles with both requests valid
//  stall_cnt    out CNT_W   cycles with stall=1
// BEHAVIOUR
//  Reset: wr_enable=0, RD=0, WD=0, busy=0, last_grant=1 (port 0 wins first tie), counters=0.
//    Reset mid-operation drops the registered write and all pending state.
//  Arbitration:
//    - One valid requester: it is granted.
//    - Both valid: grant the port != last_grant; last_grant updates on every grant.
//    - readyN = grant to N. No backpressure from the file.
//    - An ungranted requester holds valid/rd/data stable until ready.
//  Latency: accepted in cycle N -> wr_enable=1, RD, WD in cycle N+1; file writes at the end of N+1.
//    - Cycle with no grant: wr_enable=0 next cycle; RD/WD hold.
//  Out-of-range rd (rd>=8): accepted (ready=1), wr_enable stays 0, no scoreboard effect.
//  Scoreboard busy[7:0]:
//    - Set: iss_valid && iss_rd<8 sets busy[iss_rd].
//    - Clear: wr_enable && RD<8 clears busy[RD] at the same edge the file writes.
//    - Same reg set+clear in one cycle: set wins.
//  stall = OR over enabled, in-range operands of busy[chk_x].
//    - Covers RAW on rs1..rs3 and WAW on rd.
//    - Out-of-range operands never stall.
//    - Issue asserts iss_valid only when stall=0.
//  Write to a non-busy reg (no prior issue) is legal; the clear is a no-op.
// CONFIGURATION
//  VREG_WB_PERF_EN defined:
//    - conflict_cnt += 1 per cycle both req valid.
//    - stall_cnt += 1 per cycle stall=1.
//    - Both saturate at all-ones; both clear on rst.
//  Undefined: both counter outputs tied to 0, no counter flops.
// STRUCTURE
//  vreg_pkg:
//    - DATA_W, IDX_W, NUM_REGS constants.
//    - vreg_idx_t, vreg_data_t.
//    - typedef struct wb_req_t {valid, rd, data}.
//  Sub-module vreg_scoreboard: busy vector, set/clear priority, stall logic.
//  Top holds the round-robin arbiter, output register and optional counters.
// TESTING
//  1. Reset, then req0 rd=3 data=A -> ready0=1; next cycle wr_enable=1, RD=3, WD=A; one cycle later wr_enable=0.
//  2. Both valid 4 cycles, req0 rd=1, req1 rd=2, held -> grants 0,1,0,1; RD sequence 1,2,1,2; conflict_cnt=4 (PERF_EN).
//  3. iss_valid rd=5; chk rs2=5 use=0010 -> stall=1 until the cycle after the wr_enable/RD=5 edge, then 0; stall_cnt matches.
//  4. iss_valid rd=4 in the same cycle wr_enable=1, RD=4 -> busy[4] stays 1 (set wins).
//  5. req1 rd=9 -> ready1=1, wr_enable stays 0; chk rs1=9 use=0001 -> stall=0.
//  6. rst while wr_enable=1 and busy=8'hFF -> next cycle wr_enable=0, RD=0, WD=0, busy=0, stall=0, counters=0.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared constants, types and index helpers for the vector register writeback path.
// No ports; imported by the interface, the scoreboard and the arbiter top.
package vreg_pkg;

  localparam int DATA_W   = 192;
  localparam int IDX_W    = 4;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = $clog2(NUM_REGS);
  localparam int CNT_W    = 32;

  typedef logic [IDX_W-1:0]    vreg_idx_t;
  typedef logic [DATA_W-1:0]   vreg_data_t;
  typedef logic [NUM_REGS-1:0] vreg_busy_t;

  typedef struct packed {
    logic       valid;
    vreg_idx_t  rd;
    vreg_data_t data;
  } wb_req_t;

  function automatic logic idx_ok(vreg_idx_t i);
    return i < vreg_idx_t'(NUM_REGS);
  endfunction

  function automatic logic [SEL_W-1:0] idx_sel(vreg_idx_t i);
    return i[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/vreg_wb_arbiter_if.sv
// Writeback bus: two requester handshakes in, register-file write port out.
// master = requesters/file side, slave = arbiter.
interface vreg_wb_arbiter_if;
  import vreg_pkg::*;

  logic       req0_valid;
  vreg_idx_t  req0_rd;
  vreg_data_t req0_data;
  logic       req0_ready;

  logic       req1_valid;
  vreg_idx_t  req1_rd;
  vreg_data_t req1_data;
  logic       req1_ready;

  logic       wr_enable;
  vreg_idx_t  RD;
  vreg_data_t WD;

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    input  wr_enable, RD, WD
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    output wr_enable, RD, WD
  );

endinterface

// File: rtl/vreg_scoreboard.sv
// Busy scoreboard for in-flight vector destinations; flags RAW/WAW stall.
// Ports: clk, rst, iss_valid/iss_rd (set), clr_valid/clr_rd (clear), chk_* in, stall out.
module vreg_scoreboard
  import vreg_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      iss_valid,
  input  vreg_idx_t iss_rd,
  input  logic      clr_valid,
  input  vreg_idx_t clr_rd,
  input  vreg_idx_t chk_rs1,
  input  vreg_idx_t chk_rs2,
  input  vreg_idx_t chk_rs3,
  input  vreg_idx_t chk_rd,
  input  logic [3:0] chk_use,
  output logic      stall
);

  vreg_busy_t busy_q, busy_d;
  logic [3:0][IDX_W-1:0] ops;

  assign ops = {chk_rd, chk_rs3, chk_rs2, chk_rs1};

  // Clear first so a same-cycle set on that register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid && idx_ok(clr_rd))
      busy_d[idx_sel(clr_rd)] = 1'b0;
    if (iss_valid && idx_ok(iss_rd))
      busy_d[idx_sel(iss_rd)] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (chk_use[k] && idx_ok(ops[k]) &&
          busy_q[idx_sel(ops[k])])
        stall = 1'b1;
    end
  end

endmodule

// File: rtl/vreg_wb_arbiter.sv
// Round-robin writeback arbiter + output register for the vector register file.
// Ports: clk, rst, bus (slave), iss_*, chk_*, stall, conflict_cnt, stall_cnt. Macro: VREG_WB_PERF_EN.
module vreg_wb_arbiter
  import vreg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  vreg_wb_arbiter_if.slave bus,
  input  logic             iss_valid,
  input  vreg_idx_t        iss_rd,
  input  vreg_idx_t        chk_rs1,
  input  vreg_idx_t        chk_rs2,
  input  vreg_idx_t        chk_rs3,
  input  vreg_idx_t        chk_rd,
  input  logic [3:0]       chk_use,
  output logic             stall,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  wb_req_t    req0, req1;
  logic       gnt0, gnt1;
  logic       last_q, last_d;
  logic       we_q, we_d;
  vreg_idx_t  rd_q, rd_d;
  vreg_data_t wd_q, wd_d;

  assign req0 = '{bus.req0_valid, bus.req0_rd, bus.req0_data};
  assign req1 = '{bus.req1_valid, bus.req1_rd, bus.req1_data};

  // last_q=1 means port 1 won last, so port 0 takes the next tie.
  always_comb begin
    gnt0   = req0.valid && (!req1.valid || last_q);
    gnt1   = req1.valid && (!req0.valid || !last_q);
    last_d = last_q;
    we_d   = 1'b0;
    rd_d   = rd_q;
    wd_d   = wd_q;
    unique case (1'b1)
      gnt0: begin
        last_d = 1'b0;
        if (idx_ok(req0.rd)) begin
          we_d = 1'b1;
          rd_d = req0.rd;
          wd_d = req0.data;
        end
      end
      gnt1: begin
        last_d = 1'b1;
        if (idx_ok(req1.rd)) begin
          we_d = 1'b1;
          rd_d = req1.rd;
          wd_d = req1.data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.wr_enable  = we_q;
  assign bus.RD         = rd_q;
  assign bus.WD         = wd_q;

  vreg_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .clr_valid (we_q),
    .clr_rd    (rd_q),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rs3   (chk_rs3),
    .chk_rd    (chk_rd),
    .chk_use   (chk_use),
    .stall     (stall)
  );

`ifdef VREG_WB_PERF_EN
  logic [CNT_W-1:0] conf_q, stl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conf_q <= '0;
      stl_q  <= '0;
    end else begin
      if (req0.valid && req1.valid && conf_q != '1)
        conf_q <= conf_q + 1'b1;
      if (stall && stl_q != '1)
        stl_q <= stl_q + 1'b1;
    end
  end

  assign conflict_cnt = conf_q;
  assign stall_cnt    = stl_q;
`else
  assign conflict_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Randomized + directed bench for vreg_wb_arbiter against a behavioural model.
// Honours VREG_WB_PERF_EN for the counter expectations.
module tb_vreg_wb_arbiter;
  import vreg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic iss_valid;
  vreg_idx_t iss_rd, chk_rs1, chk_rs2, chk_rs3, chk_rd;
  logic [3:0] chk_use;
  logic stall;
  logic [CNT_W-1:0] conflict_cnt, stall_cnt;

  vreg_wb_arbiter_if bus();

  vreg_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .chk_rs1      (chk_rs1),
    .chk_rs2      (chk_rs2),
    .chk_rs3      (chk_rs3),
    .chk_rd       (chk_rd),
    .chk_use      (chk_use),
    .stall        (stall),
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // model state
  bit m_we;
  int m_rd;
  logic [191:0] m_wd;
  int m_last;
  bit m_busy[8];
  longint m_conf, m_stl;
  bit m_g0, m_g1;
  localparam longint CMAX = (longint'(1) << CNT_W) - 1;

  task automatic expect_eq(string tag, logic [191:0] got, logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_stall_f();
    int ops[4];
    ops[0] = int'(chk_rs1);
    ops[1] = int'(chk_rs2);
    ops[2] = int'(chk_rs3);
    ops[3] = int'(chk_rd);
    for (int k = 0; k < 4; k++)
      if (chk_use[k] && ops[k] < 8 && m_busy[ops[k]]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_we = 0; m_rd = 0; m_wd = '0; m_last = 1;
    m_conf = 0; m_stl = 0;
    for (int i = 0; i < 8; i++) m_busy[i] = 0;
  endtask

  task automatic idle();
    rst = 0; iss_valid = 0; iss_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rs3 = '0; chk_rd = '0; chk_use = '0;
    bus.req0_valid = 0; bus.req0_rd = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_rd = '0; bus.req1_data = '0;
  endtask

  // Called right after a negedge with inputs driven: checks, then advances model.
  task automatic step();
    bit s, v0, v1;
    int r0, r1;
    v0 = bus.req0_valid; v1 = bus.req1_valid;
    r0 = int'(bus.req0_rd); r1 = int'(bus.req1_rd);
    s = m_stall_f();
    if (v0 && v1) begin
      m_g0 = (m_last == 1);
      m_g1 = (m_last == 0);
    end else begin
      m_g0 = v0;
      m_g1 = v1;
    end
    #1;
    expect_eq("wr_enable", bus.wr_enable, m_we);
    expect_eq("RD", bus.RD, m_rd);
    expect_eq("WD", bus.WD, m_wd);
    expect_eq("ready0", bus.req0_ready, m_g0);
    expect_eq("ready1", bus.req1_ready, m_g1);
    expect_eq("stall", stall, s);
`ifdef VREG_WB_PERF_EN
    expect_eq("conflict_cnt", conflict_cnt, m_conf);
    expect_eq("stall_cnt", stall_cnt, m_stl);
`else
    expect_eq("conflict_cnt", conflict_cnt, 0);
    expect_eq("stall_cnt", stall_cnt, 0);
`endif
    if (rst) begin
      m_reset();
    end else begin
      if (m_we && m_rd < 8) m_busy[m_rd] = 0;
      if (iss_valid && iss_rd < 8) m_busy[iss_rd] = 1;
      if (v0 && v1 && m_conf != CMAX) m_conf++;
      if (s && m_stl != CMAX) m_stl++;
      m_we = 0;
      if (m_g0) begin
        m_last = 0;
        if (r0 < 8) begin m_we = 1; m_rd = r0; m_wd = bus.req0_data; end
      end else if (m_g1) begin
        m_last = 1;
        if (r1 < 8) begin m_we = 1; m_rd = r1; m_wd = bus.req1_data; end
      end
    end
  endtask

  task automatic rst_cycle();
    @(negedge clk); idle(); rst = 1; step();
  endtask

  function automatic vreg_idx_t rnd_idx();
    int r;
    r = $urandom_range(0, 9);
    return (r < 8) ? vreg_idx_t'(r) : vreg_idx_t'(8 + $urandom_range(0, 7));
  endfunction

  function automatic logic [191:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [191:0] A;

  initial begin
    idle();
    rst = 1;
    m_reset();
    repeat (2) @(posedge clk);

    // T1: single ALU write, one-cycle latency
    A = rnd_data();
    @(negedge clk); idle();
    bus.req0_valid = 1; bus.req0_rd = 3; bus.req0_data = A;
    step();
    expect_eq("t1_ready0", bus.req0_ready, 1);
    @(negedge clk); idle(); step();
    expect_eq("t1_we", bus.wr_enable, 1);
    expect_eq("t1_rd", bus.RD, 3);
    expect_eq("t1_wd", bus.WD, A);
    @(negedge clk); idle(); step();
    expect_eq("t1_we_off", bus.wr_enable, 0);

    // T2: sustained conflict alternates starting with port 0
    rst_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle();
      bus.req0_valid = 1; bus.req0_rd = 1; bus.req0_data = 192'h10;
      bus.req1_valid = 1; bus.req1_rd = 2; bus.req1_data = 192'h20;
      step();
      expect_eq("t2_grant0", bus.req0_ready, (i % 2) == 0);
    end
    @(negedge clk); idle(); step();
    expect_eq("t2_last_rd", bus.RD, 2);

    // T3: RAW on rs2 until the write of v5 retires
    @(negedge clk); idle(); iss_valid = 1; iss_rd = 5; step();
    @(negedge clk); idle(); chk_rs2 = 5; chk_use = 4'b0010; step();
    expect_eq("t3_stall", stall, 1);
    @(negedge clk); idle(); chk_rs2 = 5; chk_use = 4'b0010;
    bus.req0_valid = 1; bus.req0_rd = 5; bus.req0_data = 192'h55;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); chk_rs2 = 5; chk_use = 4'b0010; step();
    end
    expect_eq("t3_stall_clr", stall, 0);

    // T4: set and clear of v4 on the same edge, set wins
    @(negedge clk); idle(); iss_valid = 1; iss_rd = 4; step();
    @(negedge clk); idle();
    bus.req1_valid = 1; bus.req1_rd = 4; bus.req1_data = 192'h44;
    step();
    @(negedge clk); idle(); iss_valid = 1; iss_rd = 4; step();
    @(negedge clk); idle(); chk_rd = 4; chk_use = 4'b1000; step();
    expect_eq("t4_waw", stall, 1);

    // T5: out-of-range destination and source
    @(negedge clk); idle();
    bus.req1_valid = 1; bus.req1_rd = 9; bus.req1_data = 192'h99;
    step();
    expect_eq("t5_ready1", bus.req1_ready, 1);
    @(negedge clk); idle(); chk_rs1 = 9; chk_use = 4'b0001; step();
    expect_eq("t5_we", bus.wr_enable, 0);
    expect_eq("t5_stall", stall, 0);

    // T6: reset with a pending write and every register busy
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle(); iss_valid = 1; iss_rd = vreg_idx_t'(i); step();
    end
    @(negedge clk); idle();
    bus.req0_valid = 1; bus.req0_rd = 2; bus.req0_data = 192'hABC;
    step();
    @(negedge clk); idle(); rst = 1; step();
    expect_eq("t6_pre_we", bus.wr_enable, 1);
    @(negedge clk); idle(); chk_use = 4'hF;
    chk_rs1 = 1; chk_rs2 = 3; chk_rs3 = 6; chk_rd = 7;
    step();
    expect_eq("t6_we", bus.wr_enable, 0);
    expect_eq("t6_stall", stall, 0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      bit keep0, keep1;
      keep0 = bus.req0_valid && !m_g0 && !rst;
      keep1 = bus.req1_valid && !m_g1 && !rst;
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      if (!keep0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_rd = rnd_idx();
        bus.req0_data = rnd_data();
      end
      if (!keep1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_rd = rnd_idx();
        bus.req1_data = rnd_data();
      end
      chk_rs1 = rnd_idx(); chk_rs2 = rnd_idx();
      chk_rs3 = rnd_idx(); chk_rd = rnd_idx();
      chk_use = 4'($urandom);
      iss_rd = rnd_idx();
      iss_valid = !m_stall_f() && ($urandom_range(0, 1) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
